fp_norm_round: RTL and testbench

- Post-add stage of the single-precision FP add/sub datapath.
- Consumes the raw 25-bit significand sum and carry-out from the mantissa carry-lookahead adder, together with the sign, biased exponent and alignment sticky bit.
- Normalizes the sum with a multi-cycle left/right shifter and rounds round-to-nearest-even.
- Emits a packed IEEE-754 single-precision result with status flags over a valid/ready handshake.

---
 rtl/fp_norm_round.sv | 144 ++++++++++++++
 tb/tb_fp_norm_round.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Post-add normalize and round-to-nearest-even stage of the single-precision FP adder.
// Iterative shifter: coarse LZ_STEP left shifts where safe, otherwise single-bit steps.
module fp_norm_round #(
    parameter int LZ_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic        in_cout,
    input  logic [24:0] in_sum,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_NORM, S_ROUND, S_DONE} state_t;

    localparam logic signed [9:0] LZ_S = 10'(LZ_STEP);

    state_t             r_state;
    logic [25:0]        r_m;
    logic signed [9:0]  r_e;
    logic               r_st;
    logic               r_sg;
    logic               r_valid;
    logic [31:0]        r_result;
    logic               r_ovf;
    logic               r_unf;
    logic               r_inx;

    logic               w_up;
    logic [24:0]        w_f;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_e_rnd;
    logic               w_coarse_ok;

    // Round-to-nearest-even; a carry out of the 24-bit mantissa renormalizes by one.
    assign w_up        = r_m[0] & (r_st | r_m[1]);
    assign w_f         = {1'b0, r_m[24:1]} + {24'd0, w_up};
    assign w_frac      = w_f[24] ? w_f[23:1] : w_f[22:0];
    assign w_e_rnd     = w_f[24] ? r_e + 10'sd1 : r_e;
    assign w_coarse_ok = (r_m[24 -: LZ_STEP] == '0) && (r_e > LZ_S);

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_valid;
    assign out_result  = r_result;
    assign out_ovf     = r_ovf;
    assign out_unf     = r_unf;
    assign out_inexact = r_inx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_e      <= '0;
            r_st     <= 1'b0;
            r_sg     <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m     <= {in_cout, in_sum};
                        r_e     <= signed'({2'b00, in_exp});
                        r_st    <= in_sticky;
                        r_sg    <= in_sign;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (r_m == '0 && !r_st) begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_inx    <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_m[25]) begin
                        r_m     <= r_m >> 1;
                        r_st    <= r_st | r_m[0];
                        r_e     <= r_e + 10'sd1;
                        r_state <= S_ROUND;
                    end else if (r_m[24] && r_e >= 10'sd1) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_m[24]) begin
                        r_state <= S_ROUND;
                    end else if (r_e <= 10'sd1) begin
                        // Would go subnormal: flush to signed zero.
                        r_result <= {r_sg, 31'b0};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b1;
                        r_inx    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_coarse_ok) begin
                        r_m <= r_m << LZ_STEP;
                        r_e <= r_e - LZ_S;
                    end else begin
                        r_m <= r_m << 1;
                        r_e <= r_e - 10'sd1;
                    end
                end
                S_ROUND: begin
                    r_unf <= 1'b0;
                    if (w_e_rnd >= 10'sd255) begin
                        r_result <= {r_sg, 8'hFF, 23'b0};
                        r_ovf    <= 1'b1;
                        r_inx    <= 1'b1;
                    end else begin
                        r_result <= {r_sg, w_e_rnd[7:0], w_frac};
                        r_ovf    <= 1'b0;
                        r_inx    <= r_m[0] | r_st;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entering DONE.
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed vector table, handshake/reset sequences, and
// random operands checked against an integer-arithmetic reference model.
module tb_fp_norm_round;

    localparam int LZ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic        in_cout = 1'b0;
    logic [24:0] in_sum = '0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;

    fp_norm_round #(.LZ_STEP(LZ)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_cout(in_cout),
        .in_sum(in_sum), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf),
        .out_unf(out_unf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [7:0]  ex;
        logic        co;
        logic [24:0] sm;
        logic        st;
        logic [31:0] res;
        logic [2:0]  fl;   // {ovf, unf, inexact}
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: normalize by leading-zero count, round the 24-bit mantissa with
    // integer arithmetic, and derive latency from the number of NORM cycles spent.
    function automatic void model(input logic sg, input logic [7:0] ex, input logic co,
                                  input logic [24:0] sm, input logic st_in,
                                  output logic [31:0] res, output logic [2:0] fl,
                                  output int lat);
        logic [25:0] m;
        logic [23:0] mant;
        logic        st, g, up;
        int          e, lz, sh, cyc, f;
        m = {co, sm}; e = int'(ex); st = st_in; res = '0; fl = '0; lat = 0;
        if (m == '0 && !st) begin
            lat = 2;
            return;
        end
        if (m[25]) begin
            st = st | m[0];
            m = m >> 1;
            e = e + 1;
            lat = 3;
        end else if (m[24] && e >= 1) begin
            lat = 3;
        end else begin
            lz = 1000;
            for (int b = 24; b >= 0; b--) if (m[b]) begin lz = 24 - b; break; end
            sh = lz;
            cyc = 0;
            while (1) begin
                cyc++;
                if (lz == 0) break;
                if (e <= 1) begin
                    res = {sg, 31'b0};
                    fl = 3'b011;
                    lat = cyc + 2;
                    return;
                end
                if (lz >= LZ && e > LZ) begin lz -= LZ; e -= LZ; end
                else begin lz -= 1; e -= 1; end
            end
            m = m << sh;
            lat = cyc + 3;
        end
        mant = m[24:1];
        g = m[0];
        up = g & (st | mant[0]);
        f = int'(mant) + int'(up);
        if (f >= (1 << 24)) begin f = f >> 1; e = e + 1; end
        if (e >= 255) begin
            res = {sg, 8'hFF, 23'b0};
            fl = 3'b101;
        end else begin
            res = {sg, e[7:0], f[22:0]};
            fl = {2'b00, g | st};
        end
    endfunction

    // Issue one operand, wait for out_valid, optionally stall the output, then complete.
    task automatic run_op(input logic sg, input logic [7:0] ex, input logic co,
                          input logic [24:0] sm, input logic st, input int hold,
                          output logic [31:0] res, output logic [2:0] fl, output int lat);
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b1; in_sign = sg; in_exp = ex; in_cout = co; in_sum = sm; in_sticky = st;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        fl = {out_ovf, out_unf, out_inexact};
        if (!out_valid) begin
            rst = 1'b1; #1; rst = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_result", out_result, res);
            chk("hold_flags", {29'd0, out_ovf, out_unf, out_inexact}, {29'd0, fl});
            chk("hold_valid_busy", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_chk(input string nm, input vec_t v, input int hold);
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        run_op(v.sg, v.ex, v.co, v.sm, v.st, hold, r, f, l);
        chk({nm, "_result"}, r, v.res);
        chk({nm, "_flags"}, {29'd0, f}, {29'd0, v.fl});
        chk({nm, "_latency"}, 32'(l), 32'(v.lat));
    endtask

    vec_t tbl[14];

    initial begin
        vec_t v;
        tbl[0]  = '{1'b0, 8'd127, 1'b1, 25'h0000000, 1'b0, 32'h40000000, 3'b000, 3};
        tbl[1]  = '{1'b0, 8'd127, 1'b0, 25'h0000002, 1'b0, 32'h34000000, 3'b000, 12};
        tbl[2]  = '{1'b0, 8'd127, 1'b0, 25'h1FFFFFF, 1'b0, 32'h40000000, 3'b001, 3};
        tbl[3]  = '{1'b0, 8'd127, 1'b0, 25'h1000001, 1'b0, 32'h3F800000, 3'b001, 3};
        tbl[4]  = '{1'b0, 8'd127, 1'b0, 25'h1000001, 1'b1, 32'h3F800001, 3'b001, 3};
        tbl[5]  = '{1'b1, 8'd254, 1'b1, 25'h0000000, 1'b0, 32'hFF800000, 3'b101, 3};
        tbl[6]  = '{1'b0, 8'd100, 1'b0, 25'h0000000, 1'b0, 32'h00000000, 3'b000, 2};
        tbl[7]  = '{1'b1, 8'd3,   1'b0, 25'h0000002, 1'b0, 32'h80000000, 3'b011, 5};
        tbl[8]  = '{1'b0, 8'd0,   1'b1, 25'h0000000, 1'b0, 32'h00800000, 3'b000, 3};
        tbl[9]  = '{1'b0, 8'd10,  1'b0, 25'h0000000, 1'b1, 32'h00000000, 3'b011, 6};
        tbl[10] = '{1'b0, 8'd5,   1'b0, 25'h0000002, 1'b0, 32'h00000000, 3'b011, 4};
        tbl[11] = '{1'b0, 8'd127, 1'b1, 25'h0000001, 1'b0, 32'h40000000, 3'b001, 3};
        tbl[12] = '{1'b0, 8'd127, 1'b1, 25'h0000002, 1'b0, 32'h40000000, 3'b001, 3};
        tbl[13] = '{1'b0, 8'd127, 1'b1, 25'h0000006, 1'b0, 32'h40000002, 3'b001, 3};

        #2 rst = 1'b1;
        #1;
        chk("reset_result", out_result, 32'h0);
        chk("reset_flags_valid_ready", {28'd0, out_valid, out_ovf, out_unf, out_inexact, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_chk($sformatf("vec%0d", i), tbl[i], 0);

        // Backpressure: result and flags must hold while the consumer stalls.
        run_chk("stall", tbl[5], 5);

        // Reset while normalizing: operation discarded, outputs return to reset values.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_cout = 1'b0;
        in_sum = 25'h0000002; in_sticky = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_result", out_result, 32'h0);
        chk("midrst_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_chk("after_rst", tbl[0], 0);

        for (int n = 0; n < 300; n++) begin
            v.sg = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       v.ex = 8'($urandom_range(0, 8));
                1:       v.ex = 8'($urandom_range(248, 254));
                default: v.ex = 8'($urandom_range(1, 254));
            endcase
            v.co = ($urandom_range(0, 3) == 0);
            v.sm = v.co ? 25'($urandom) : (25'($urandom) >> $urandom_range(0, 25));
            v.st = 1'($urandom);
            model(v.sg, v.ex, v.co, v.sm, v.st, v.res, v.fl, v.lat);
            run_chk($sformatf("rnd%0d", n), v, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
